// File: rtl/bram_macro_model.sv
// Behavioural 256x32 block-RAM macro: lane-addressed narrow read/write, read-first
// collisions, one or two output registers selected by the mode byte.
module bram_macro_model #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] rd_addr,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [7:0]    cfg,      // mode byte
   output logic [DW-1:0] rd_data
);

   typedef enum logic [1:0] {
      W32 = 2'd0,
      W16 = 2'd1,
      W8  = 2'd2
   } width_t;

   // Encoding 11 is reserved and behaves as full width.
   function automatic width_t decode_width(input logic [1:0] code);
      case (code)
         2'b01:   decode_width = W16;
         2'b10:   decode_width = W8;
         default: decode_width = W32;
      endcase
   endfunction

   function automatic logic [AW-1:0] word_of(input width_t w, input logic [AW-1:0] addr);
      case (w)
         W16:     word_of = {1'b0, addr[AW-1:1]};
         W8:      word_of = {2'b00, addr[AW-1:2]};
         default: word_of = addr;
      endcase
   endfunction

   logic [DW-1:0] mem [DEPTH];

   width_t        wr_width, rd_width;
   logic          wr_en;
   logic [AW-1:0] wr_word, rd_word;
   logic [3:0]    wr_be;
   logic [DW-1:0] wr_bits;
   logic [DW-1:0] rd_raw, rd_next;
   logic [DW-1:0] stage1, stage2;
   logic          unused_cfg;

   assign unused_cfg = cfg[7];
   assign wr_width   = decode_width(cfg[1:0]);
   assign rd_width   = decode_width(cfg[3:2]);
   assign wr_en      = cfg[4] | cfg[5];
   assign wr_word    = word_of(wr_width, wr_addr);
   assign rd_word    = word_of(rd_width, rd_addr);

   // Narrow data is replicated across all lanes; the byte enables pick the target lane.
   always_comb begin
      wr_be   = 4'hF;
      wr_bits = wr_data;
      case (wr_width)
         W16: begin
            wr_be   = wr_addr[0] ? 4'b1100 : 4'b0011;
            wr_bits = {2{wr_data[15:0]}};
         end
         W8: begin
            wr_be   = 4'b0001 << wr_addr[1:0];
            wr_bits = {4{wr_data[7:0]}};
         end
         default: ;
      endcase
   end

   // Reset intentionally does not gate the array.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_word][8*b +: 8] <= wr_bits[8*b +: 8];
         end
      end
   end

   always_comb begin
      rd_raw  = mem[rd_word];
      rd_next = rd_raw;
      case (rd_width)
         W16: rd_next = {16'h0000, rd_addr[0] ? rd_raw[31:16] : rd_raw[15:0]};
         W8:  rd_next = {24'h000000, rd_raw[8*rd_addr[1:0] +: 8]};
         default: ;
      endcase
   end

   // Non-blocking array update gives read-first behaviour on same-word collisions.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage1 <= '0;
         stage2 <= '0;
      end else begin
         stage1 <= rd_next;
         stage2 <= stage1;
      end
   end

   assign rd_data = cfg[6] ? stage2 : stage1;

endmodule

// File: tb/tb_bram_macro_model.sv
// Scoreboard bench for bram_macro_model: expected read data is queued with its due
// edge when a read is driven, then compared on the falling edge after it.
module tb_bram_macro_model;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rd_addr, wr_addr, cfg;
   logic [31:0] wr_data, rd_data;

   bram_macro_model #(.DEPTH(256), .AW(8), .DW(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .rd_addr (rd_addr),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .cfg     (cfg),
      .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] exp;
      string       tag;
   } sb_t;

   sb_t sb[$];
   int  edges = 0;
   int  n_cmp = 0;
   int  n_bad = 0;

   always @(posedge clk) edges++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, edges);
      end
   endtask

   // Read result due 'lat' edges after the next edge's predecessor, i.e. after edge edges+lat.
   task automatic expect_rd(input string tag, input logic [31:0] exp, input int lat);
      sb_t e;
      e.due = edges + lat;
      e.exp = exp;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic step(input logic r, input logic [7:0] ra, input logic [7:0] wa,
                       input logic [31:0] wd, input logic [7:0] c);
      rst = r; rd_addr = ra; wr_addr = wa; wr_data = wd; cfg = c;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= edges) begin
         sb_t e;
         e = sb.pop_front();
         chk(e.tag, rd_data, e.exp);
      end
   end

   initial begin
      logic [7:0] nb, pb;
      rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; cfg = 8'h00;

      // Reset state: pipeline cleared even though memory is X.
      expect_rd("reset0", 32'h0, 1);
      step(1'b1, 8'd0, 8'd0, 32'h0, 8'h00);
      expect_rd("reset1", 32'h0, 1);
      step(1'b1, 8'd0, 8'd0, 32'h0, 8'h00);

      // Counter pattern, first pass.
      for (int n = 0; n < 256; n++) begin
         nb = n[7:0];
         pb = nb - 8'd1;
         if (n >= 1) expect_rd($sformatf("cnt_k%0d", pb), {4{pb}}, 1);
         step(1'b0, pb, nb, {4{nb}}, 8'h10);
      end

      // Second pass with inverted data; rst held for two cycles mid-stream.
      for (int n = 0; n < 111; n++) begin
         nb = n[7:0];
         pb = nb - 8'd1;
         if (n == 100 || n == 101) begin
            expect_rd("rst_mid", 32'h0, 1);
            step(1'b1, pb, nb, ~{4{nb}}, 8'h10);
         end else begin
            if (n == 0) expect_rd("cnt_wrap255", {4{8'hFF}}, 1);
            else        expect_rd($sformatf("cnt2_k%0d", pb), ~{4{pb}}, 1);
            step(1'b0, pb, nb, ~{4{nb}}, 8'h10);
         end
      end
      for (int k = 200; k < 205; k++) begin
         expect_rd($sformatf("intact_%0d", k), {4{k[7:0]}}, 1);
         step(1'b0, k[7:0], 8'd0, 32'h0, 8'h00);
      end

      // Read-first collision.
      step(1'b0, 8'd0, 8'd5, 32'h11111111, 8'h10);
      expect_rd("rdfirst_old", 32'h11111111, 1);
      step(1'b0, 8'd5, 8'd5, 32'h22222222, 8'h10);
      expect_rd("rdfirst_new", 32'h22222222, 1);
      step(1'b0, 8'd5, 8'd0, 32'h0, 8'h00);

      // Narrow lanes.
      step(1'b0, 8'd0, 8'd1, 32'h00000000, 8'h10);
      step(1'b0, 8'd0, 8'd6, 32'hFFFFFFA5, 8'h12);
      expect_rd("narrow_rd32", 32'h00A50000, 1);
      step(1'b0, 8'd1, 8'd0, 32'h0, 8'h00);
      expect_rd("narrow_rd16", 32'h000000A5, 1);
      step(1'b0, 8'd3, 8'd0, 32'h0, 8'h04);
      expect_rd("narrow_rd8", 32'h000000A5, 1);
      step(1'b0, 8'd6, 8'd0, 32'h0, 8'h08);
      step(1'b0, 8'd0, 8'd2, 32'hABCD1234, 8'h11);
      expect_rd("narrow_wr16", 32'h00A51234, 1);
      step(1'b0, 8'd1, 8'd0, 32'h0, 8'h00);
      expect_rd("narrow_rd16_lo", 32'h00001234, 1);
      step(1'b0, 8'd2, 8'd0, 32'h0, 8'h04);

      // Write gating.
      step(1'b0, 8'd0, 8'd9, 32'h01020304, 8'h10);
      step(1'b0, 8'd0, 8'd9, 32'hDEADBEEF, 8'h00);
      expect_rd("gate_off", 32'h01020304, 1);
      step(1'b0, 8'd9, 8'd0, 32'h0, 8'h00);
      step(1'b0, 8'd0, 8'd9, 32'hDEADBEEF, 8'h20);
      expect_rd("gate_strobe", 32'hDEADBEEF, 1);
      step(1'b0, 8'd9, 8'd0, 32'h0, 8'h00);

      // Latency 2; scratch word 255 absorbs the always-on writes.
      step(1'b0, 8'd0, 8'd7, 32'hCAFEF00D, 8'h10);
      step(1'b0, 8'd0, 8'd8, 32'h12345678, 8'h10);
      expect_rd("lat2_prev", 32'h12345678, 2);
      step(1'b0, 8'd8, 8'd255, 32'h0, 8'h50);
      expect_rd("lat2_data", 32'hCAFEF00D, 2);
      step(1'b0, 8'd7, 8'd255, 32'h0, 8'h50);
      step(1'b0, 8'd7, 8'd255, 32'h0, 8'h50);
      step(1'b0, 8'd7, 8'd255, 32'h0, 8'h50);

      // Every queued expectation must have been reached.
      chk("sb_drain", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
